// File: rtl/pipelined_cpu.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with EX forwarding,
// single-cycle load-use stall and branch/jump resolution in ID.

module cpu_pc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic [31:0] i_next_pc,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc_o <= 32'd0;
        else if (!i_stall) pc_o <= i_next_pc;
    end
endmodule

module cpu_imem #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] memory [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (i_we) memory[i_waddr] <= i_wdata;
    end

    assign o_rdata = memory[i_raddr];
endmodule

module cpu_dmem #(
    parameter int unsigned BYTES = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [7:0]    memory [0:BYTES-1];
    logic [AW-1:0] w_a    [0:3];

    // Byte lanes of a little-endian word; addresses wrap within the array
    always_comb begin
        for (int k = 0; k < 4; k++) w_a[k] = i_addr + AW'(k);
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < 4; k++) memory[w_a[k]] <= i_wdata[8*k +: 8];
        end
    end

    assign o_rdata = {memory[w_a[3]], memory[w_a[2]], memory[w_a[1]], memory[w_a[0]]};
endmodule

module cpu_regfile (
    input  logic        clk,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk) begin
        if (i_we && i_waddr != 5'd0) register[i_waddr] <= i_wdata;
    end

    // Same-cycle WB write is visible to ID reads
    always_comb begin
        o_rdata_a = register[i_raddr_a];
        if (i_raddr_a == 5'd0)                     o_rdata_a = 32'd0;
        else if (i_we && i_waddr == i_raddr_a)     o_rdata_a = i_wdata;
        o_rdata_b = register[i_raddr_b];
        if (i_raddr_b == 5'd0)                     o_rdata_b = 32'd0;
        else if (i_we && i_waddr == i_raddr_b)     o_rdata_b = i_wdata;
    end
endmodule

module cpu_if_id (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        Flush_i,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pc4   <= 32'd0;
            o_instr <= 32'd0;
        end else if (Flush_i) begin
            o_pc4   <= 32'd0;
            o_instr <= 32'd0;
        end else if (!i_stall) begin
            o_pc4   <= i_pc4;
            o_instr <= i_instr;
        end
    end
endmodule

module cpu_hazard (
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    output logic       MuxSelect_o
);
    assign MuxSelect_o = i_idex_mem_read &&
                         (i_idex_rt == i_ifid_rs || i_idex_rt == i_ifid_rt);
endmodule

module cpu_control (
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_equal,
    input  logic       i_stall,
    output logic       o_reg_write,
    output logic       o_mem_to_reg,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_alu_src,
    output logic       o_reg_dst,
    output logic       o_r_type,
    output logic       Jump_o,
    output logic       Branch_o
);
    logic w_is_beq;
    logic w_is_j;

    always_comb begin
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_alu_src    = 1'b0;
        o_reg_dst    = 1'b0;
        o_r_type     = 1'b0;
        w_is_beq     = 1'b0;
        w_is_j       = 1'b0;
        case (i_op)
            6'h00: begin
                // Only recognised functs write back; anything else is a NOP
                if (i_funct == 6'h20 || i_funct == 6'h22 || i_funct == 6'h24 ||
                    i_funct == 6'h25 || i_funct == 6'h18) begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = 1'b1;
                    o_r_type    = 1'b1;
                end
            end
            6'h08: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
            end
            6'h23: begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_mem_to_reg = 1'b1;
                o_mem_read   = 1'b1;
            end
            6'h2B: begin
                o_alu_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            6'h04:   w_is_beq = 1'b1;
            6'h02:   w_is_j   = 1'b1;
            default: ;
        endcase
    end

    // A load-use stall suppresses the redirect for this cycle
    assign Jump_o   = w_is_j && !i_stall;
    assign Branch_o = w_is_beq && i_equal && !i_stall;
endmodule

module pipelined_cpu #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_BYTES = 32
) (
    input  logic clk_i,
    input  logic start_i
);
    localparam int unsigned IA_W = $clog2(IMEM_WORDS);
    localparam int unsigned DA_W = $clog2(DMEM_BYTES);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

    logic [31:0] w_pc, w_pc4, w_next_pc, w_instr;
    logic [31:0] w_ifid_pc4, w_ifid_instr;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm, w_rs_data, w_rt_data, w_br_target, w_j_target;
    logic        w_stall, w_jump, w_branch, w_flush, w_equal;
    logic        w_c_reg_write, w_c_mem_to_reg, w_c_mem_read, w_c_mem_write;
    logic        w_c_alu_src, w_c_reg_dst, w_c_r_type;

    logic        r_idex_reg_write, r_idex_mem_to_reg, r_idex_mem_read, r_idex_mem_write;
    logic        r_idex_alu_src, r_idex_reg_dst, r_idex_r_type;
    logic [31:0] r_idex_rs_data, r_idex_rt_data, r_idex_imm;
    logic [4:0]  r_idex_rs, r_idex_rt, r_idex_rd;

    logic        r_exmem_reg_write, r_exmem_mem_to_reg, r_exmem_mem_write;
    logic [31:0] r_exmem_alu, r_exmem_store;
    logic [4:0]  r_exmem_dst;

    logic        r_memwb_reg_write, r_memwb_mem_to_reg;
    logic [31:0] r_memwb_alu, r_memwb_load;
    logic [4:0]  r_memwb_dst;

    logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu, w_mem_rdata, w_wb_data;
    logic [4:0]  w_ex_dst;
    alu_op_e     w_alu_op;

    // IF
    assign w_pc4 = w_pc + 32'd4;

    cpu_pc PC (
        .clk(clk_i), .rst_n(start_i), .i_stall(w_stall),
        .i_next_pc(w_next_pc), .pc_o(w_pc)
    );

    cpu_imem #(.WORDS(IMEM_WORDS), .AW(IA_W)) Instruction_Memory (
        .clk(clk_i), .i_we(1'b0), .i_waddr(IA_W'(0)), .i_wdata(32'd0),
        .i_raddr(w_pc[IA_W+1:2]), .o_rdata(w_instr)
    );

    cpu_if_id IF_ID (
        .clk(clk_i), .rst_n(start_i), .i_stall(w_stall), .Flush_i(w_flush),
        .i_pc4(w_pc4), .i_instr(w_instr), .o_pc4(w_ifid_pc4), .o_instr(w_ifid_instr)
    );

    // ID
    assign w_rs    = w_ifid_instr[25:21];
    assign w_rt    = w_ifid_instr[20:16];
    assign w_rd    = w_ifid_instr[15:11];
    assign w_imm   = {{16{w_ifid_instr[15]}}, w_ifid_instr[15:0]};
    assign w_equal = (w_rs_data == w_rt_data);

    cpu_regfile Registers (
        .clk(clk_i), .i_we(r_memwb_reg_write), .i_waddr(r_memwb_dst), .i_wdata(w_wb_data),
        .i_raddr_a(w_rs), .i_raddr_b(w_rt), .o_rdata_a(w_rs_data), .o_rdata_b(w_rt_data)
    );

    cpu_hazard Hazard_Detection (
        .i_idex_mem_read(r_idex_mem_read), .i_idex_rt(r_idex_rt),
        .i_ifid_rs(w_rs), .i_ifid_rt(w_rt), .MuxSelect_o(w_stall)
    );

    cpu_control Control (
        .i_op(w_ifid_instr[31:26]), .i_funct(w_ifid_instr[5:0]),
        .i_equal(w_equal), .i_stall(w_stall),
        .o_reg_write(w_c_reg_write), .o_mem_to_reg(w_c_mem_to_reg),
        .o_mem_read(w_c_mem_read), .o_mem_write(w_c_mem_write),
        .o_alu_src(w_c_alu_src), .o_reg_dst(w_c_reg_dst), .o_r_type(w_c_r_type),
        .Jump_o(w_jump), .Branch_o(w_branch)
    );

    assign w_br_target = w_ifid_pc4 + {w_imm[29:0], 2'b00};
    assign w_j_target  = {w_ifid_pc4[31:28], w_ifid_instr[25:0], 2'b00};
    assign w_flush     = w_jump || w_branch;
    assign w_next_pc   = w_jump ? w_j_target : (w_branch ? w_br_target : w_pc4);

    // ID/EX; a stall turns the entering slot into a bubble
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_idex_reg_write  <= 1'b0;
            r_idex_mem_to_reg <= 1'b0;
            r_idex_mem_read   <= 1'b0;
            r_idex_mem_write  <= 1'b0;
            r_idex_alu_src    <= 1'b0;
            r_idex_reg_dst    <= 1'b0;
            r_idex_r_type     <= 1'b0;
            r_idex_rs_data    <= 32'd0;
            r_idex_rt_data    <= 32'd0;
            r_idex_imm        <= 32'd0;
            r_idex_rs         <= 5'd0;
            r_idex_rt         <= 5'd0;
            r_idex_rd         <= 5'd0;
        end else begin
            r_idex_reg_write  <= w_c_reg_write  && !w_stall;
            r_idex_mem_to_reg <= w_c_mem_to_reg && !w_stall;
            r_idex_mem_read   <= w_c_mem_read   && !w_stall;
            r_idex_mem_write  <= w_c_mem_write  && !w_stall;
            r_idex_alu_src    <= w_c_alu_src    && !w_stall;
            r_idex_reg_dst    <= w_c_reg_dst    && !w_stall;
            r_idex_r_type     <= w_c_r_type     && !w_stall;
            r_idex_rs_data    <= w_rs_data;
            r_idex_rt_data    <= w_rt_data;
            r_idex_imm        <= w_imm;
            r_idex_rs         <= w_rs;
            r_idex_rt         <= w_rt;
            r_idex_rd         <= w_rd;
        end
    end

    // EX operand forwarding: EX/MEM has priority over MEM/WB
    always_comb begin
        w_fwd_a = r_idex_rs_data;
        if (r_exmem_reg_write && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rs)
            w_fwd_a = r_exmem_alu;
        else if (r_memwb_reg_write && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rs)
            w_fwd_a = w_wb_data;
        w_fwd_b = r_idex_rt_data;
        if (r_exmem_reg_write && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rt)
            w_fwd_b = r_exmem_alu;
        else if (r_memwb_reg_write && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rt)
            w_fwd_b = w_wb_data;
    end

    always_comb begin
        w_alu_op = ALU_ADD;
        if (r_idex_r_type) begin
            case (r_idex_imm[5:0])
                6'h22:   w_alu_op = ALU_SUB;
                6'h24:   w_alu_op = ALU_AND;
                6'h25:   w_alu_op = ALU_OR;
                6'h18:   w_alu_op = ALU_MUL;
                default: w_alu_op = ALU_ADD;
            endcase
        end
    end

    assign w_alu_b  = r_idex_alu_src ? r_idex_imm : w_fwd_b;
    assign w_ex_dst = r_idex_reg_dst ? r_idex_rd : r_idex_rt;

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu = w_fwd_a - w_alu_b;
            ALU_AND: w_alu = w_fwd_a & w_alu_b;
            ALU_OR:  w_alu = w_fwd_a | w_alu_b;
            ALU_MUL: w_alu = 32'(w_fwd_a * w_alu_b);
            default: w_alu = w_fwd_a + w_alu_b;
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_exmem_reg_write  <= 1'b0;
            r_exmem_mem_to_reg <= 1'b0;
            r_exmem_mem_write  <= 1'b0;
            r_exmem_alu        <= 32'd0;
            r_exmem_store      <= 32'd0;
            r_exmem_dst        <= 5'd0;
        end else begin
            r_exmem_reg_write  <= r_idex_reg_write;
            r_exmem_mem_to_reg <= r_idex_mem_to_reg;
            r_exmem_mem_write  <= r_idex_mem_write;
            r_exmem_alu        <= w_alu;
            r_exmem_store      <= w_fwd_b;
            r_exmem_dst        <= w_ex_dst;
        end
    end

    // MEM
    cpu_dmem #(.BYTES(DMEM_BYTES), .AW(DA_W)) Data_Memory (
        .clk(clk_i), .i_we(r_exmem_mem_write), .i_addr(r_exmem_alu[DA_W-1:0]),
        .i_wdata(r_exmem_store), .o_rdata(w_mem_rdata)
    );

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_memwb_reg_write  <= 1'b0;
            r_memwb_mem_to_reg <= 1'b0;
            r_memwb_alu        <= 32'd0;
            r_memwb_load       <= 32'd0;
            r_memwb_dst        <= 5'd0;
        end else begin
            r_memwb_reg_write  <= r_exmem_reg_write;
            r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
            r_memwb_alu        <= r_exmem_alu;
            r_memwb_load       <= w_mem_rdata;
            r_memwb_dst        <= r_exmem_dst;
        end
    end

    // WB
    assign w_wb_data = r_memwb_mem_to_reg ? r_memwb_load : r_memwb_alu;
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed programs for pipelined_cpu: forwarding, load-use stall, store,
// taken branch, jump, ALU ops and r0 behaviour.

module tb_pipelined_cpu;
    logic clk   = 1'b0;
    logic start = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   stall_cnt = 0;
    int   flush_cnt = 0;
    int   s0;
    int   f0;

    always #5 clk = ~clk;

    pipelined_cpu dut (.clk_i(clk), .start_i(start));

    always @(negedge clk) begin
        if (start) begin
            if (dut.Hazard_Detection.MuxSelect_o && !dut.Control.Jump_o && !dut.Control.Branch_o)
                stall_cnt++;
            if (dut.IF_ID.Flush_i)
                flush_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rg(input int i);
        return dut.Registers.register[i];
    endfunction

    function automatic logic [31:0] dword(input int a);
        return {dut.Data_Memory.memory[a+3], dut.Data_Memory.memory[a+2],
                dut.Data_Memory.memory[a+1], dut.Data_Memory.memory[a]};
    endfunction

    // Hold reset and zero program, data and register state
    task automatic clear_state();
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
        for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 8'd0;
        for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'd0;
        @(negedge clk);
    endtask

    task automatic release_cpu();
        s0 = stall_cnt;
        f0 = flush_cnt;
        start = 1'b1;
    endtask

    initial begin
        // Forwarding chain plus reset behaviour
        clear_state();
        dut.Registers.register[20] = 32'h0000_1234;
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 0, 8, 16'd5);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 0, 9, 16'd3);
        dut.Instruction_Memory.memory[2] = enc_r(8, 9, 10, 6'h20);
        #1 check("reset_pc", dut.PC.pc_o, 32'd0);
        @(negedge clk);
        release_cpu();
        #1 check("pc_first_edge", dut.PC.pc_o, 32'd0);
        @(posedge clk); #1;
        check("pc_next_cycle", dut.PC.pc_o, 32'd4);
        repeat (16) @(negedge clk);
        check("fwd_r8", rg(8), 32'd5);
        check("fwd_r9", rg(9), 32'd3);
        check("fwd_r10", rg(10), 32'd8);
        check("fwd_stalls", 32'(stall_cnt - s0), 32'd0);
        check("fwd_flushes", 32'(flush_cnt - f0), 32'd0);
        check("reset_keeps_r20", rg(20), 32'h0000_1234);

        // Load-use stall then forwarded store
        clear_state();
        dut.Data_Memory.memory[0] = 8'd5;
        dut.Instruction_Memory.memory[0] = enc_i(6'h23, 0, 8, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_r(8, 8, 9, 6'h20);
        dut.Instruction_Memory.memory[2] = enc_i(6'h2B, 0, 9, 16'd4);
        release_cpu();
        repeat (18) @(negedge clk);
        check("lw_r8", rg(8), 32'd5);
        check("lu_r9", rg(9), 32'd10);
        check("lu_stalls", 32'(stall_cnt - s0), 32'd1);
        check("lu_flushes", 32'(flush_cnt - f0), 32'd0);
        check("sw_word4", dword(4), 32'h0000_000A);

        // Taken beq skips two instructions
        clear_state();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 0, 1, 16'd1);
        dut.Instruction_Memory.memory[1] = enc_i(6'h04, 0, 0, 16'd2);
        dut.Instruction_Memory.memory[2] = enc_i(6'h08, 0, 2, 16'd7);
        dut.Instruction_Memory.memory[3] = enc_i(6'h08, 0, 3, 16'd9);
        dut.Instruction_Memory.memory[4] = enc_i(6'h08, 0, 4, 16'd4);
        release_cpu();
        repeat (18) @(negedge clk);
        check("beq_r1", rg(1), 32'd1);
        check("beq_skip_r2", rg(2), 32'd0);
        check("beq_skip_r3", rg(3), 32'd0);
        check("beq_target_r4", rg(4), 32'd4);
        check("beq_flushes", 32'(flush_cnt - f0), 32'd1);
        check("beq_stalls", 32'(stall_cnt - s0), 32'd0);

        // Jump to word 0x10 (byte 0x40)
        clear_state();
        dut.Instruction_Memory.memory[0]  = {6'h02, 26'h10};
        dut.Instruction_Memory.memory[1]  = enc_i(6'h08, 0, 5, 16'd1);
        dut.Instruction_Memory.memory[16] = enc_i(6'h08, 0, 6, 16'd6);
        release_cpu();
        @(posedge clk); #1;
        check("j_pc_fetch", dut.PC.pc_o, 32'd4);
        @(posedge clk); #1;
        check("j_pc_target", dut.PC.pc_o, 32'h40);
        repeat (16) @(negedge clk);
        check("j_skip_r5", rg(5), 32'd0);
        check("j_target_r6", rg(6), 32'd6);
        check("j_flushes", 32'(flush_cnt - f0), 32'd1);

        // ALU ops on 7 and 3, r0 write discard, negative immediate
        clear_state();
        dut.Registers.register[1] = 32'd7;
        dut.Registers.register[2] = 32'd3;
        dut.Instruction_Memory.memory[0] = enc_r(1, 2, 11, 6'h22);
        dut.Instruction_Memory.memory[1] = enc_r(1, 2, 12, 6'h24);
        dut.Instruction_Memory.memory[2] = enc_r(1, 2, 13, 6'h25);
        dut.Instruction_Memory.memory[3] = enc_r(1, 2, 14, 6'h18);
        dut.Instruction_Memory.memory[4] = enc_i(6'h08, 0, 0, 16'd5);
        dut.Instruction_Memory.memory[5] = enc_r(0, 1, 15, 6'h20);
        dut.Instruction_Memory.memory[6] = enc_i(6'h08, 1, 16, 16'hFFF8);
        release_cpu();
        repeat (20) @(negedge clk);
        check("sub_r11", rg(11), 32'd4);
        check("and_r12", rg(12), 32'd3);
        check("or_r13", rg(13), 32'd7);
        check("mul_r14", rg(14), 32'd21);
        check("r0_stays_zero", rg(0), 32'd0);
        check("r0_not_forwarded", rg(15), 32'd7);
        check("addi_neg_r16", rg(16), 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
